// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: mux select encodings and
// the bit layout of a shadow-pipeline slot.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Slot layout, LSB first: valid, regWrite, memRead, then rd at [SL_RD +: REG_BITS]
    localparam int SL_VLD = 0;
    localparam int SL_WR  = 1;
    localparam int SL_MR  = 2;
    localparam int SL_RD  = 3;

    function automatic int slot_bits(input int reg_bits);
        return reg_bits + SL_RD;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request fields and EX-stage forwarding/stall responses.
interface fwd_hazard_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 32
);
    logic [REG_BITS-1:0] IdRs;
    logic [REG_BITS-1:0] IdRt;
    logic                IdUsesRs;
    logic                IdUsesRt;
    logic [REG_BITS-1:0] IdRd;
    logic                IdRegWrite;
    logic                IdMemRead;
    logic                Flush;
    logic [1:0]          FwdASel;
    logic [1:0]          FwdBSel;
    logic                Stall;
    logic [CNT_BITS-1:0] StallCount;

    modport master (
        output IdRs, IdRt, IdUsesRs, IdUsesRt, IdRd, IdRegWrite, IdMemRead, Flush,
        input  FwdASel, FwdBSel, Stall, StallCount
    );

    modport slave (
        input  IdRs, IdRt, IdUsesRs, IdUsesRt, IdRd, IdRegWrite, IdMemRead, Flush,
        output FwdASel, FwdBSel, Stall, StallCount
    );
endinterface

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding select: nearest writing producer wins, r0 never forwards.
module fwd_operand_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0]       src_i,
    input  logic                      uses_i,
    input  logic [REG_BITS+SL_RD-1:0] ex_slot_i,
    input  logic [REG_BITS+SL_RD-1:0] mem_slot_i,
    output logic [1:0]                sel_o
);
    logic [REG_BITS-1:0] ex_rd, mem_rd;
    logic                ex_hit, mem_hit;
    logic                unused_mem_mr;

    assign ex_rd  = ex_slot_i[SL_RD +: REG_BITS];
    assign mem_rd = mem_slot_i[SL_RD +: REG_BITS];

    // A load in EX has no ALU result yet; the load-use stall covers it.
    assign ex_hit  = ex_slot_i[SL_VLD] & ex_slot_i[SL_WR] & ~ex_slot_i[SL_MR]
                   & (ex_rd != '0) & (ex_rd == src_i);
    assign mem_hit = mem_slot_i[SL_VLD] & mem_slot_i[SL_WR]
                   & (mem_rd != '0) & (mem_rd == src_i);
    assign unused_mem_mr = mem_slot_i[SL_MR];

    always_comb begin
        sel_o = FWD_REG;
        if (uses_i) begin
            if (ex_hit)       sel_o = FWD_EXMEM;
            else if (mem_hit) sel_o = FWD_MEMWB;
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow EX/MEM/WB destination tracking, registered operand-mux selects,
// combinational load-use stall and a saturating stall counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 32
) (
    input logic             Clk,
    input logic             Rst,
    fwd_hazard_unit_if.slave io
);
    localparam int SW = slot_bits(REG_BITS);

    logic [SW-1:0]       id_slot, ex_slot_d, ex_slot_q, mem_slot_q, wb_slot_q;
    logic [1:0]          sel_a, sel_b, fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [CNT_BITS-1:0] cnt_d, cnt_q;
    logic [REG_BITS-1:0] ex_rd;
    logic                load_use, stall, bubble;
    logic                unused_wb;

    assign id_slot = {io.IdRd, io.IdMemRead, io.IdRegWrite, 1'b1};
    assign ex_rd   = ex_slot_q[SL_RD +: REG_BITS];

    assign load_use = ex_slot_q[SL_VLD] & ex_slot_q[SL_MR] & (ex_rd != '0)
                    & ((io.IdUsesRs & (ex_rd == io.IdRs)) | (io.IdUsesRt & (ex_rd == io.IdRt)));
    assign stall    = load_use & ~io.Flush;
    assign bubble   = stall | io.Flush;

    fwd_operand_sel #(.REG_BITS(REG_BITS)) u_sel_a (
        .src_i(io.IdRs), .uses_i(io.IdUsesRs),
        .ex_slot_i(ex_slot_q), .mem_slot_i(mem_slot_q), .sel_o(sel_a)
    );

    fwd_operand_sel #(.REG_BITS(REG_BITS)) u_sel_b (
        .src_i(io.IdRt), .uses_i(io.IdUsesRt),
        .ex_slot_i(ex_slot_q), .mem_slot_i(mem_slot_q), .sel_o(sel_b)
    );

    always_comb begin
        ex_slot_d = bubble ? '0 : id_slot;
        fwd_a_d   = bubble ? FWD_REG : sel_a;
        fwd_b_d   = bubble ? FWD_REG : sel_b;
        cnt_d     = cnt_q;
        if (stall && !(&cnt_q)) cnt_d = cnt_q + CNT_BITS'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_slot_q  <= '0;
            mem_slot_q <= '0;
            wb_slot_q  <= '0;
            fwd_a_q    <= FWD_REG;
            fwd_b_q    <= FWD_REG;
            cnt_q      <= '0;
        end else begin
            wb_slot_q  <= mem_slot_q;
            mem_slot_q <= ex_slot_q;
            ex_slot_q  <= ex_slot_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            cnt_q      <= cnt_d;
        end
    end

    // WB producers are served by the write-before-read register file.
    assign unused_wb = ^wb_slot_q;

    assign io.FwdASel    = fwd_a_q;
    assign io.FwdBSel    = fwd_b_q;
    assign io.Stall      = stall;
    assign io.StallCount = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random instruction streams against a producer-list reference
// model; expected selects are queued at issue and compared one edge later.
module tb_fwd_hazard_unit;

    localparam int RB = 5;
    localparam int CB = 4;

    typedef struct packed {
        logic          v;
        logic [RB-1:0] rd;
        logic          wr;
        logic          mr;
    } mslot_t;

    logic Clk, Rst;
    int   errors, checks;

    fwd_hazard_unit_if #(.REG_BITS(RB), .CNT_BITS(CB)) io ();

    fwd_hazard_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
        .Clk(Clk), .Rst(Rst), .io(io.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    mslot_t     m_ex, m_mem, m_wb;
    int         m_cnt;
    logic [3:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mref(input logic [RB-1:0] src, input logic rd_en);
        mslot_t p[2];
        p[0] = m_ex;
        p[1] = m_mem;
        if (!rd_en || src == 0) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (p[k].v && p[k].wr && p[k].rd == src) begin
                if (k == 1) return 2'b10;
                if (!p[k].mr) return 2'b01;
            end
        end
        return 2'b00;
    endfunction

    function automatic logic mload_use(input logic [RB-1:0] rs, rt, input logic urs, urt);
        if (!(m_ex.v && m_ex.mr) || m_ex.rd == 0) return 1'b0;
        return (urs && rs == m_ex.rd) || (urt && rt == m_ex.rd);
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic idle();
        io.IdRs = '0; io.IdRt = '0; io.IdUsesRs = 1'b0; io.IdUsesRt = 1'b0;
        io.IdRd = '0; io.IdRegWrite = 1'b0; io.IdMemRead = 1'b0; io.Flush = 1'b0;
    endtask

    // One ID-stage cycle: drive, check Stall, queue selects, clock, compare.
    task automatic step(input logic [RB-1:0] rs, rt, input logic urs, urt,
                        input logic [RB-1:0] rd, input logic wr, mr, fl);
        logic       e_stall, bub;
        logic [3:0] got;
        @(negedge Clk);
        io.IdRs = rs; io.IdRt = rt; io.IdUsesRs = urs; io.IdUsesRt = urt;
        io.IdRd = rd; io.IdRegWrite = wr; io.IdMemRead = mr; io.Flush = fl;
        #1;
        e_stall = mload_use(rs, rt, urs, urt) && !fl;
        bub     = e_stall || fl;
        chk("stall", 32'(io.Stall), 32'(e_stall));
        sb_q.push_back(bub ? 4'b0000 : {mref(rs, urs), mref(rt, urt)});
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = bub ? '0 : mslot_t'{1'b1, rd, wr, mr};
        if (e_stall && m_cnt < (1 << CB) - 1) m_cnt++;
        @(posedge Clk);
        #1;
        got = sb_q.pop_front();
        chk("selA", 32'(io.FwdASel), 32'(got[3:2]));
        chk("selB", 32'(io.FwdBSel), 32'(got[1:0]));
        chk("sel_not_11", 32'(io.FwdASel == 2'b11 || io.FwdBSel == 2'b11), 32'd0);
        chk("count", 32'(io.StallCount), 32'(m_cnt));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();
        idle();
        Rst = 1'b1;
        #2;
        chk("rst_selA", 32'(io.FwdASel), 32'd0);
        chk("rst_selB", 32'(io.FwdBSel), 32'd0);
        chk("rst_stall", 32'(io.Stall), 32'd0);
        chk("rst_count", 32'(io.StallCount), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // add r3,r1,r2 ; sub r4,r3,r5
        step(1, 2, 1, 1, 3, 1, 0, 0);
        step(3, 5, 1, 1, 4, 1, 0, 0);
        chk("sub_A_exmem", 32'(io.FwdASel), 32'h1);
        chk("sub_B_reg",   32'(io.FwdBSel), 32'h0);

        // add r3 ; nop ; or r6,r1,r3
        step(1, 2, 1, 1, 3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 1, 1, 6, 1, 0, 0);
        chk("or_B_memwb", 32'(io.FwdBSel), 32'h2);

        // add r3 ; add r3 ; or r6,r3,r3 -> nearest wins
        step(1, 2, 1, 1, 3, 1, 0, 0);
        step(2, 1, 1, 1, 3, 1, 0, 0);
        step(3, 3, 1, 1, 6, 1, 0, 0);
        chk("near_A", 32'(io.FwdASel), 32'h1);
        chk("near_B", 32'(io.FwdBSel), 32'h1);

        // lw r2,0(r1) ; add r4,r2,r2 (stalls once, then forwards from WB)
        step(1, 0, 1, 0, 2, 1, 1, 0);
        step(2, 2, 1, 1, 4, 1, 0, 0);
        chk("lu_count", 32'(io.StallCount), 32'd1);
        step(2, 2, 1, 1, 4, 1, 0, 0);
        chk("lu_A_memwb", 32'(io.FwdASel), 32'h2);
        chk("lu_B_memwb", 32'(io.FwdBSel), 32'h2);

        // r0 writes never forward or stall
        step(1, 2, 1, 1, 0, 1, 0, 0);
        step(0, 0, 1, 1, 4, 1, 0, 0);
        chk("r0_A", 32'(io.FwdASel), 32'h0);
        step(1, 0, 1, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 4, 1, 0, 0);
        chk("r0_count", 32'(io.StallCount), 32'd1);

        // load-use coinciding with Flush
        step(1, 0, 1, 0, 7, 1, 1, 0);
        step(7, 0, 1, 0, 4, 1, 0, 1);
        chk("fl_count", 32'(io.StallCount), 32'd1);
        chk("fl_A", 32'(io.FwdASel), 32'h0);
        step(7, 0, 1, 0, 4, 1, 0, 0);

        // back-to-back dependent loads
        step(5, 0, 1, 0, 1, 1, 1, 0);
        step(1, 0, 1, 0, 2, 1, 1, 0);
        step(1, 0, 1, 0, 2, 1, 1, 0);
        chk("ldld_A", 32'(io.FwdASel), 32'h2);
        chk("ldld_count", 32'(io.StallCount), 32'd2);

        // asynchronous reset mid-stream
        step(1, 2, 1, 1, 3, 1, 0, 0);
        step(3, 3, 1, 1, 6, 1, 0, 0);
        @(negedge Clk);
        idle();
        Rst = 1'b1;
        #1;
        chk("mrst_selA", 32'(io.FwdASel), 32'd0);
        chk("mrst_selB", 32'(io.FwdBSel), 32'd0);
        chk("mrst_count", 32'(io.StallCount), 32'd0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        step(3, 6, 1, 1, 4, 1, 0, 0);
        chk("post_rst_A", 32'(io.FwdASel), 32'h0);

        // random stream
        for (int i = 0; i < 150; i++) begin
            step(RB'($urandom_range(0, 7)), RB'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 RB'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // drive enough load-use stalls to saturate the counter
        for (int i = 0; i < 18; i++) begin
            step(1, 0, 1, 0, 5, 1, 1, 0);
            step(5, 0, 1, 0, 4, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("sat_count", 32'(io.StallCount), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
